// File: rtl/ats21_instr_decoder_if.sv
// ATS21 host instruction bus plus the decoded-command handshake to the core.
// master: host/core side driving requests and cmd_ready.
// slave : the instruction decoder.
interface ats21_instr_decoder_if;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_src;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_id;
  logic [3:0]  cmd_clk;
  logic [1:0]  cmd_arg;
  logic [4:0]  cmd_mode;
  logic [15:0] cmd_value;

  modport master (
    output req, ctrlA, ctrlB, cmd_ready,
    input  ready, stat, cmd_valid, cmd_src, cmd_op, cmd_id, cmd_clk,
           cmd_arg, cmd_mode, cmd_value
  );

  modport slave (
    input  req, ctrlA, ctrlB, cmd_ready,
    output ready, stat, cmd_valid, cmd_src, cmd_op, cmd_id, cmd_clk,
           cmd_arg, cmd_mode, cmd_value
  );
endinterface

// File: rtl/ats21_instr_decoder.sv
// ATS21 instruction decoder: captures two-beat instructions from clients A
// and B, checks legality, and serialises the resulting commands (A first)
// to the core over a valid/ready handshake.
//
// Optional build macro ATS21_PERMISSION_CHECK_EN adds a mode register
// (written by op 011 from client A) that gates ops by per-client
// permission bits and a global active bit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready high, waiting for req; beat 1 latched on req
// BEAT2    | beat 2 on the bus; both slots decoded and checked this cycle
// DISPATCH | pending slots offered to the core, A before B
module ats21_instr_decoder #(
  parameter int NUM_CLOCKS = 16,
  parameter int NUM_ATS    = 32
) (
  input logic                  clk,
  input logic                  reset,
  ats21_instr_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BEAT2    = 2'd1,
    S_DISPATCH = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  id;
    logic [3:0]  clk_ref;
    logic [1:0]  arg;
    logic [4:0]  mode;
    logic [15:0] value;
  } slot_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLK1 = 3'b001;
  localparam logic [2:0] OP_CLK2 = 3'b010;
  localparam logic [2:0] OP_MODE = 3'b011;
  localparam logic [2:0] OP_BAD  = 3'b100;
  localparam logic [2:0] OP_AT1  = 3'b101;
  localparam logic [2:0] OP_AT2  = 3'b110;
  localparam logic [2:0] OP_AT3  = 3'b111;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_OK      = 2'b01;
  localparam logic [1:0] STAT_ILLEGAL = 2'b10;
  localparam logic [1:0] STAT_OVERRUN = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] b1_a_q, b1_b_q;
  slot_t       slot_a_q, slot_b_q;
  slot_t       slot_a_d, slot_b_d;
  logic        a_pend_q, b_pend_q;
  logic [1:0]  stat_q;
  logic        legal_a, legal_b;
  logic        valid_a, valid_b;
  logic        illegal_any;
  logic        overrun;

  // Bits [5:4] of beat 1 carry no field.
  logic unused_beat1_bits;
  assign unused_beat1_bits = ^{b1_a_q[5:4], b1_b_q[5:4]};

  function automatic slot_t decode_slot(input logic [15:0] b1, input logic [15:0] b2);
    slot_t s;
    s.op      = b1[15:13];
    s.id      = ((b1[15:13] == OP_CLK1) || (b1[15:13] == OP_CLK2)) ?
                {1'b0, b1[12:9]} : b1[12:8];
    s.clk_ref = b1[3:0];
    s.arg     = b1[7:6];
    s.mode    = b1[12:8];
    s.value   = b2;
    return s;
  endfunction

  // Opcode and id-range legality, independent of permissions.
  function automatic logic range_ok(input slot_t s);
    int clk_id;
    int at_id;
    clk_id = int'(s.id[3:0]);
    at_id  = int'(s.id);
    case (s.op)
      OP_BAD:                  return 1'b0;
      OP_CLK1, OP_CLK2:        return clk_id < NUM_CLOCKS;
      OP_AT1, OP_AT2, OP_AT3:  return at_id < NUM_ATS;
      default:                 return 1'b1;
    endcase
  endfunction

`ifdef ATS21_PERMISSION_CHECK_EN
  // mode layout: [4] active, [3:2] AT perms {B,A}, [1:0] BC perms {B,A}
  logic [4:0] mode_q;
  logic [4:0] mode_for_b;

  function automatic logic perm_ok(input slot_t s, input logic src_b, input logic [4:0] mode);
    case (s.op)
      OP_MODE:                 return !src_b;
      OP_CLK1, OP_CLK2:        return mode[4] && (src_b ? mode[1] : mode[0]);
      OP_AT1, OP_AT2, OP_AT3:  return mode[4] && (src_b ? mode[3] : mode[2]);
      default:                 return 1'b1;
    endcase
  endfunction
`endif

  // Decode both slots from latched beat 1 and the live beat 2.
  always_comb begin
    slot_a_d = decode_slot(b1_a_q, bus.ctrlA);
    slot_b_d = decode_slot(b1_b_q, bus.ctrlB);
`ifdef ATS21_PERMISSION_CHECK_EN
    // B sees the mode that A's simultaneous op 011 is about to write.
    mode_for_b = (slot_a_d.op == OP_MODE) ? slot_a_d.mode : mode_q;
    legal_a = range_ok(slot_a_d) && perm_ok(slot_a_d, 1'b0, mode_q);
    legal_b = range_ok(slot_b_d) && perm_ok(slot_b_d, 1'b1, mode_for_b);
`else
    legal_a = range_ok(slot_a_d);
    legal_b = range_ok(slot_b_d);
`endif
    valid_a     = (slot_a_d.op != OP_NOP) && legal_a;
    valid_b     = (slot_b_d.op != OP_NOP) && legal_b;
    illegal_any = ((slot_a_d.op != OP_NOP) && !legal_a) ||
                  ((slot_b_d.op != OP_NOP) && !legal_b);
  end

  assign overrun = bus.req && (state_q != S_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.req) state_d = S_BEAT2;
      S_BEAT2:    state_d = (valid_a || valid_b) ? S_DISPATCH : S_IDLE;
      S_DISPATCH: begin
        // Leave once the last pending slot is taken.
        if (bus.cmd_ready && !(a_pend_q && b_pend_q)) state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Beat capture, slot registers and dispatch bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b1_a_q   <= '0;
      b1_b_q   <= '0;
      slot_a_q <= '0;
      slot_b_q <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            b1_a_q <= bus.ctrlA;
            b1_b_q <= bus.ctrlB;
          end
        end
        S_BEAT2: begin
          slot_a_q <= slot_a_d;
          slot_b_q <= slot_b_d;
          a_pend_q <= valid_a;
          b_pend_q <= valid_b;
        end
        S_DISPATCH: begin
          if (bus.cmd_ready) begin
            if (a_pend_q) a_pend_q <= 1'b0;
            else          b_pend_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Host status: overrun takes priority and sticks until the next decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= STAT_NONE;
    end else if (overrun) begin
      stat_q <= STAT_OVERRUN;
    end else if (state_q == S_BEAT2) begin
      if (illegal_any)            stat_q <= STAT_ILLEGAL;
      else if (valid_a || valid_b) stat_q <= STAT_OK;
      else                        stat_q <= STAT_NONE;
    end
  end

`ifdef ATS21_PERMISSION_CHECK_EN
  // Mode register, written by client A's op 011 at decode time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                             mode_q <= 5'b1_11_11;
    else if ((state_q == S_BEAT2) && (slot_a_d.op == OP_MODE)) mode_q <= slot_a_d.mode;
  end
`endif

  // Outputs: ready in IDLE, selected slot fields while a command is offered.
  always_comb begin
    slot_t sel;
    sel           = a_pend_q ? slot_a_q : slot_b_q;
    bus.ready     = (state_q == S_IDLE);
    bus.stat      = stat_q;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_id    = '0;
    bus.cmd_clk   = '0;
    bus.cmd_arg   = '0;
    bus.cmd_mode  = '0;
    bus.cmd_value = '0;
    if ((state_q == S_DISPATCH) && (a_pend_q || b_pend_q)) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_src   = !a_pend_q;
      bus.cmd_op    = sel.op;
      bus.cmd_id    = sel.id;
      bus.cmd_clk   = sel.clk_ref;
      bus.cmd_arg   = sel.arg;
      bus.cmd_mode  = sel.mode;
      bus.cmd_value = sel.value;
    end
  end

endmodule

// File: doc/ats21_instr_decoder.md
Name: ats21_instr_decoder

Overview:
- Receiving end of the ATS21 host instruction interface.
- Captures the two-beat, 32-bit instructions that clients A and B present on ctrlA/ctrlB after a req pulse, and decodes opcode and fields.
- Serialises the resulting commands (A before B) to the ATS21 core over a valid/ready handshake.
- Reports acceptance, illegal-opcode and overrun status back to the host via ready/stat.

Parameters:
- NUM_CLOCKS, 16, number of base clocks; a clock id >= NUM_CLOCKS is illegal.
- NUM_ATS, 32, number of alarms/timers; an alarm id >= NUM_ATS is illegal.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  host request; high for exactly one cycle with beat 1 on ctrlA/ctrlB.
- ctrlA  in  16  client A instruction beat (bits [31:16] in the req cycle, [15:0] in the next cycle).
- ctrlB  in  16  client B instruction beat, same timing as ctrlA.
- ready  out  1  high when a new req will be accepted.
- stat  out  2  00 none, 01 accepted, 10 illegal, 11 overrun.
- cmd_valid  out  1  decoded command available to the core.
- cmd_ready  in  1  core accepts the command when cmd_valid && cmd_ready.
- cmd_src  out  1  0 = client A, 1 = client B.
- cmd_op  out  3  opcode.
- cmd_id  out  5  alarm/timer id (bits [12:8]) for ops 101/110/111; {0, clock id [12:9]} for ops 001/010.
- cmd_clk  out  4  bits [3:0] of beat 1 (clock reference for ops 101/110).
- cmd_arg  out  2  beat 1 bits [7:6] (rate for 001; [7] = enable/repeat).
- cmd_mode  out  5  beat 1 bits [12:8] (op 011: active, AT permissions, BC permissions).
- cmd_value  out  16  beat 2 (alarm time or interval).

Behaviour:
- Reset (reset = 0) takes effect immediately:
  - ready = 1, stat = 00, cmd_valid = 0, all cmd_* fields = 0, FSM = IDLE, both capture slots empty.
- Reset mid-operation discards all captured instructions; no command is emitted for them.

FSM:
- IDLE (ready = 1):
  - req = 1 → latch ctrlA/ctrlB as beat 1 → BEAT2.
- BEAT2 (ready = 0):
  - Latch ctrlA/ctrlB unconditionally as beat 2, then decode both slots.
  - A slot is valid if its opcode is not 000 and it is legal.
  - → DISPATCH if any slot is valid, else → IDLE.
- DISPATCH (ready = 0):
  - Present the A slot first if valid, then the B slot.
  - Each slot is held stable until cmd_ready is sampled high.
  - After the last valid slot is accepted → IDLE; ready = 1 the cycle after.

Latency and back-to-back:
- With cmd_ready held high: req at cycle N, cmd_valid (A) at N+2, B at N+3, ready = 1 at N+4 (one command: N+3).
- The earliest next req is the cycle ready is high; back-to-back issue is allowed.

Legality:
- Illegal when any of the following holds:
  - opcode 100;
  - clock id >= NUM_CLOCKS (ops 001/010);
  - alarm id >= NUM_ATS (ops 101/110/111).
- An illegal slot is dropped; the other slot is still issued.
- Opcode 000 is a NOP: never emitted, not illegal.

stat (registered; updated in the cycle after BEAT2 and held until the next update):
- 10 if any slot is illegal, else 01 if any slot is valid, else 00.
- Overrun: req = 1 while ready = 0 is ignored (no capture) and sets stat = 11 the next cycle.
- 11 persists until the next accepted instruction's status overwrites it.
- Overrun during BEAT2 does not corrupt the in-flight beat 2 capture.

Field rules:
- All cmd_* fields are driven from the selected slot, and are 0 when cmd_valid = 0.
- Unused bits are passed through but carry no meaning.

Optional Feature:
- Macro: ATS21_PERMISSION_CHECK_EN.
- With the macro defined:
  - An internal mode register resets to 5'b1_11_11.
  - Op 011 is legal only from client A; it updates the register at decode and is still emitted.
  - Op 011 from client B is illegal.
  - Ops 001/010 from client X are illegal unless BC permission bit X is set (bit [8] = A, bit [9] = B).
  - Ops 101/110/111 follow the same rule with the AT permission bits (bit [10] = A, bit [11] = B).
  - Active = 0 makes every non-011 op illegal.
  - When A's 011 and a B op arrive together, B is checked against the new mode.
- Without the macro: no mode register, op 011 is emitted from either client, and no permission check is made.

Test Plan:
- Single A command: A = 2000/0000, B = 0000/0000, cmd_ready = 1 → one command (src 0, op 001, id 0, arg 00) at N+2; stat = 01; ready high at N+3.
- Both clients: A = 2000/0000, B = 2240/0000 → A at N+2, then B (op 001, id 1, arg 01) at N+3; B held while cmd_ready is low for 3 cycles.
- Alarm and countdown: A = A080/0090 → op 101, id 0, arg 10, cmd_value 0090. Then A = C102/0010 → op 110, id 1, cmd_clk 2, cmd_value 0010.
- Illegal opcode: A = 8000/0000, B = 2240/0000 → only B emitted; stat = 10.
- Overrun, then reset:
  - req re-asserted in the BEAT2 cycle → beat 2 still correct; stat = 11 until the next accepted req.
  - reset asserted with cmd_valid high and cmd_ready low → cmd_valid = 0 and ready = 1 immediately.
- Permission check (ATS21_PERMISSION_CHECK_EN only): A = 7100/0000 (BC permission A only) → accepted. Then B = 2240/0000 → illegal; stat = 10; no command emitted.
